sonar_ping_scheduler: RTL
=========================

// Module: sonar_ping_scheduler
// PURPOSE
//  Sequences one sonar ping across the SonarOnChip channel array: clears the channel filters,
//  drives a transmit burst, blanks the echo comparators, then captures a per-channel
//  time-of-flight (TOF) stamp on the first comparator hit inside a listen window.
//  Sits beside the PCM/PDM clock-enable generators; it consumes ce_pcm and the cmp vector,
//  and drives mclear to the channels. Configuration and results are exposed to the Wishbone
//  register file.
// PARAMETERS
//  NCH    10  number of sonar channels (cmp_i / hit_o width), 1..16
//  TOF_W  16  width of the tick counter and TOF stamps
// PORTS
//  wb_clk_i      in   1          system clock
//  wb_rst_i      in   1          synchronous active-high reset
//  ce_pcm        in   1          PCM-rate tick; all timing counts these ticks
//  start_i       in   1          one-cycle ping request
//  abort_i       in   1          cancel ping in progress
//  irq_clr_i     in   1          clear sticky irq_o
//  burst_len_i   in   8          TX burst length in ticks (0 is treated as 1)
//  blank_len_i   in   TOF_W      tick count at which echo capture opens
//  window_len_i  in   TOF_W      tick count at which listening ends
//  cmp_i         in   NCH        per-channel echo comparator outputs
//  tof_sel_i     in   4          channel index for tof_o readback
//  mclear_o      out  1          one-cycle clear pulse to the channel filters
//  tx_o          out  1          transmit burst gate
//  busy_o        out  1          high in every state except IDLE
//  done_o        out  1          one-cycle pulse at ping completion
//  irq_o         out  1          sticky: ping completed with at least one hit
//  hit_o         out  NCH        per-channel captured flag
//  tof_o         out  TOF_W      TOF stamp of channel tof_sel_i; 0 if tof_sel_i >= NCH
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; hit and tof[] cleared; tcnt=0.
//  States: IDLE -> CLEAR -> TX -> BLANK -> LISTEN -> DONE -> IDLE.
//  IDLE
//   - start_i=1: latch burst/blank/window; clear hit, tof[] and irq_o; go to CLEAR.
//   - start_i is ignored in any other state.
//  CLEAR
//   - One cycle with mclear_o=1; tcnt<=0; then TX.
//  tcnt
//   - Increments on each ce_pcm in TX, BLANK and LISTEN; saturates at 2^TOF_W-1.
//  TX
//   - tx_o=1.
//   - Exits to BLANK on the cycle ce_pcm=1 and tcnt==max(burst,1)-1.
//     tx_o falls on that cycle's next edge, giving exactly max(burst,1) ticks high.
//  BLANK
//   - cmp_i is ignored.
//   - Exits to LISTEN on the first cycle tcnt>=blank_len.
//   - If blank_len <= burst length, BLANK lasts one cycle.
//  LISTEN
//   - Each cycle, for every k with cmp_i[k]=1 and hit[k]=0: hit[k]<=1, tof[k]<=tcnt.
//     Multiple channels may capture in the same cycle.
//   - Exits to DONE when all NCH hits are set (including hits captured this cycle) or tcnt>=window_len.
//   - A cmp in the same cycle as window expiry is captured.
//  DONE
//   - One cycle: done_o=1; irq_o<=1 if |hit; then IDLE.
//  irq_o
//   - Cleared by irq_clr_i or a new start_i.
//   - If a set and irq_clr_i coincide, set wins.
//  abort_i
//   - In any non-IDLE state: IDLE next cycle; tx_o=0; no done_o; no irq_o change.
//   - hit and tof[] keep their partial values.
//  Config inputs changed mid-ping have no effect until the next start_i.
//  tof_o and hit_o are combinational reads of the registers, with zero latency.
// TESTING
//  T1 ce_pcm every 5 clk, burst=4, blank=10, window=100; cmp_i[2] rises at tcnt=37
//     -> tx_o high for 20 clk, tof[2]=37, hit_o=0x004, done_o at tcnt=100, irq_o=1.
//  T2 All 10 cmp bits asserted staggered by tcnt 50
//     -> hit_o=0x3FF, DONE the cycle after the last capture, long before window=100.
//  T3 cmp_i=0x3FF held during TX and BLANK (tcnt 0..9), released at tcnt 9
//     -> hit_o=0, done_o at tcnt=100, irq_o=0.
//  T4 abort_i in LISTEN at tcnt=20
//     -> busy_o=0 next cycle, no done_o pulse, earlier hits retained.
//     wb_rst_i mid-TX -> tx_o=0, IDLE, hit_o=0.
//  T5 start_i while busy -> ignored, config unchanged.
//     cmp_i[5] rises on the expiry cycle -> hit_o[5]=1, tof[5]=100.
//  T6 burst=0 -> tx_o high for exactly 1 tick.
//     irq_clr_i with irq_o=1 -> irq_o=0 next cycle.
//     tof_sel_i=12 -> tof_o=0.

Source files
------------

// File: rtl/sonar_ping_scheduler.sv
// Sequences one sonar ping: filter clear, TX burst, echo blanking, then a listen window
// that stamps each channel's first comparator hit with the current PCM tick count.
module sonar_ping_scheduler #(
    parameter int NCH   = 10,
    parameter int TOF_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             ce_pcm,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             irq_clr_i,
    input  logic [7:0]       burst_len_i,
    input  logic [TOF_W-1:0] blank_len_i,
    input  logic [TOF_W-1:0] window_len_i,
    input  logic [NCH-1:0]   cmp_i,
    input  logic [3:0]       tof_sel_i,
    output logic             mclear_o,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             irq_o,
    output logic [NCH-1:0]   hit_o,
    output logic [TOF_W-1:0] tof_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_TX,
        S_BLANK,
        S_LISTEN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [TOF_W-1:0] tcnt_q, tcnt_d;
    logic [7:0]       burst_q, burst_d;
    logic [TOF_W-1:0] blank_q, blank_d;
    logic [TOF_W-1:0] window_q, window_d;
    logic [NCH-1:0]   hit_q, hit_d;
    logic [TOF_W-1:0] tof_q [NCH];
    logic [TOF_W-1:0] tof_d [NCH];
    logic             irq_q, irq_d;
    logic [7:0]       burst_last;
    logic             counting;

    // A zero burst length still produces one tick of transmit.
    assign burst_last = (burst_q == 8'd0) ? 8'd0 : burst_q - 8'd1;
    assign counting   = (state_q == S_TX) || (state_q == S_BLANK) || (state_q == S_LISTEN);

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        burst_d  = burst_q;
        blank_d  = blank_q;
        window_d = window_q;
        hit_d    = hit_q;
        tof_d    = tof_q;
        irq_d    = irq_q;

        if (counting && ce_pcm && (tcnt_q != '1)) begin
            tcnt_d = tcnt_q + TOF_W'(1);
        end
        if (irq_clr_i) begin
            irq_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    burst_d  = burst_len_i;
                    blank_d  = blank_len_i;
                    window_d = window_len_i;
                    hit_d    = '0;
                    for (int k = 0; k < NCH; k++) tof_d[k] = '0;
                    irq_d    = 1'b0;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                tcnt_d  = '0;
                state_d = S_TX;
            end
            S_TX: begin
                if (ce_pcm && (tcnt_q == TOF_W'(burst_last))) begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                if (tcnt_q >= blank_q) begin
                    state_d = S_LISTEN;
                end
            end
            S_LISTEN: begin
                // Only the first hit per channel is stamped; later edges are ignored.
                for (int k = 0; k < NCH; k++) begin
                    if (cmp_i[k] && !hit_q[k]) begin
                        hit_d[k] = 1'b1;
                        tof_d[k] = tcnt_q;
                    end
                end
                if ((&hit_d) || (tcnt_q >= window_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (|hit_q) begin
                    irq_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort drops the ping without completion; captures so far are kept as they were.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            hit_d   = hit_q;
            tof_d   = tof_q;
            irq_d   = irq_clr_i ? 1'b0 : irq_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            tcnt_q   <= '0;
            burst_q  <= '0;
            blank_q  <= '0;
            window_q <= '0;
            hit_q    <= '0;
            for (int k = 0; k < NCH; k++) tof_q[k] <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            burst_q  <= burst_d;
            blank_q  <= blank_d;
            window_q <= window_d;
            hit_q    <= hit_d;
            tof_q    <= tof_d;
            irq_q    <= irq_d;
        end
    end

    assign mclear_o = (state_q == S_CLEAR);
    assign tx_o     = (state_q == S_TX);
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign irq_o    = irq_q;
    assign hit_o    = hit_q;

    always_comb begin
        tof_o = '0;
        for (int k = 0; k < NCH; k++) begin
            if (tof_sel_i == 4'(k)) begin
                tof_o = tof_q[k];
            end
        end
    end

endmodule
